// File: rtl/axis_rr_pkt_arbiter.sv
// Packet-level round-robin arbiter: P_CH_NUM AXI-Stream requesters share one egress.
// A channel is granted in IDLE, locked through its tlast handshake, then the priority
// pointer rotates past it. No data storage: egress is a combinational mux of the granted
// channel, and backpressure passes straight through to that channel's tready.
// Optional feature macro: ARB_PKT_CNT_EN adds o_pkt_cnt, 16-bit per-channel counts of
// completed packets (wrapping).
module axis_rr_pkt_arbiter #(
  parameter int unsigned P_CH_NUM = 4,
  parameter int unsigned P_DATA_W = 64,
  parameter int unsigned P_USER_W = 80,
  parameter int unsigned P_KEEP_W = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [P_CH_NUM*P_DATA_W-1:0] s_axis_data,
  input  logic [P_CH_NUM*P_USER_W-1:0] s_axis_user,
  input  logic [P_CH_NUM*P_KEEP_W-1:0] s_axis_keep,
  input  logic [P_CH_NUM-1:0]          s_axis_last,
  input  logic [P_CH_NUM-1:0]          s_axis_valid,
  output logic [P_CH_NUM-1:0]          s_axis_ready,
  output logic [P_DATA_W-1:0]          m_axis_out_data,
  output logic [P_USER_W-1:0]          m_axis_out_user,
  output logic [P_KEEP_W-1:0]          m_axis_out_keep,
  output logic                         m_axis_out_last,
  output logic                         m_axis_out_valid,
  input  logic                         m_axis_out_ready,
  output logic [P_CH_NUM-1:0]          o_grant,
  output logic                         o_busy
`ifdef ARB_PKT_CNT_EN
  ,
  output logic [P_CH_NUM*16-1:0]       o_pkt_cnt
`endif
);

  localparam int unsigned PtrW = (P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [P_CH_NUM-1:0] grant_q, grant_d;
  logic [PtrW-1:0]     gidx_q, gidx_d;  // binary index of grant, 0 while idle
  logic [PtrW-1:0]     ptr_q, ptr_d;    // highest-priority channel for next arbitration
  logic [PtrW-1:0]     pick_idx;
  logic                pick_vld;
  logic                send;
  logic                last_hs;

  assign send    = (state_q == StSend);
  assign last_hs = send && s_axis_valid[gidx_q] && m_axis_out_ready && s_axis_last[gidx_q];

  // Round-robin search: first requester from ptr_q upward, wrapping to channel 0.
  always_comb begin
    int unsigned j;
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = 0;
    for (int unsigned i = 0; i < P_CH_NUM; i++) begin
      j = 32'(ptr_q) + i;
      if (j >= P_CH_NUM) j = j - P_CH_NUM;
      if (!pick_vld && s_axis_valid[PtrW'(j)]) begin
        pick_vld = 1'b1;
        pick_idx = PtrW'(j);
      end
    end
  end

  // Egress mux and ready steering; gidx_q is 0 in idle so the mux shows channel 0 there.
  always_comb begin
    m_axis_out_data  = s_axis_data[gidx_q*P_DATA_W +: P_DATA_W];
    m_axis_out_user  = s_axis_user[gidx_q*P_USER_W +: P_USER_W];
    m_axis_out_keep  = s_axis_keep[gidx_q*P_KEEP_W +: P_KEEP_W];
    m_axis_out_last  = s_axis_last[gidx_q];
    m_axis_out_valid = send && s_axis_valid[gidx_q];
    s_axis_ready     = '0;
    if (send) s_axis_ready[gidx_q] = m_axis_out_ready;
  end

  // Next-state logic: grant on any request in idle, release on the tlast handshake.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d           = StSend;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
        end
      end
      StSend: begin
        if (last_hs) begin
          state_d = StIdle;
          grant_d = '0;
          gidx_d  = '0;
          ptr_d   = (gidx_q == PtrW'(P_CH_NUM - 1)) ? '0 : gidx_q + PtrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = send;

`ifdef ARB_PKT_CNT_EN
  logic [P_CH_NUM-1:0][15:0] cnt_q;

  // Completed-packet counters, one per channel, wrapping at 16 bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (last_hs) begin
      cnt_q[gidx_q] <= cnt_q[gidx_q] + 16'd1;
    end
  end

  assign o_pkt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_axis_rr_pkt_arbiter.sv
// Scoreboard bench for axis_rr_pkt_arbiter: a driver issues random packets per channel
// and pushes each beat into a per-channel expected queue; a negedge monitor checks the
// arbitration outcome against a packet-level round-robin model and pops/compares beats.
module tb_axis_rr_pkt_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [79:0] user;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic           clk = 1'b0;
  logic           i_rst;
  logic [N*64-1:0] s_data;
  logic [N*80-1:0] s_user;
  logic [N*8-1:0]  s_keep;
  logic [N-1:0]    s_last;
  logic [N-1:0]    s_valid;
  logic [N-1:0]    s_ready;
  logic [63:0]     m_data;
  logic [79:0]     m_user;
  logic [7:0]      m_keep;
  logic            m_last;
  logic            m_valid;
  logic            m_rdy;
  logic [N-1:0]    grant;
  logic            busy;
`ifdef ARB_PKT_CNT_EN
  logic [N*16-1:0] pkt_cnt;
`endif

  axis_rr_pkt_arbiter dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .s_axis_data      (s_data),
    .s_axis_user      (s_user),
    .s_axis_keep      (s_keep),
    .s_axis_last      (s_last),
    .s_axis_valid     (s_valid),
    .s_axis_ready     (s_ready),
    .m_axis_out_data  (m_data),
    .m_axis_out_user  (m_user),
    .m_axis_out_keep  (m_keep),
    .m_axis_out_last  (m_last),
    .m_axis_out_valid (m_valid),
    .m_axis_out_ready (m_rdy),
    .o_grant          (grant),
    .o_busy           (busy)
`ifdef ARB_PKT_CNT_EN
    ,
    .o_pkt_cnt        (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  beat_t drv_q[N][$];
  beat_t exp_q[N][$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    hs_cnt[N];
  logic [N-1:0] hs = '0;
  int    gap_pct = 0;
  int    rdy_mode = 0;

  // reference model: packet-level round robin
  logic  model_ok = 1'b0;
  logic  mb_busy;
  int    mb_g;
  int    mb_ptr;
  logic [15:0] mb_cnt[N];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat(input logic last);
    beat_t b;
    b.data = {$urandom(), $urandom()};
    b.user = {$urandom(), $urandom(), 16'($urandom())};
    b.keep = 8'($urandom());
    b.last = last;
    return b;
  endfunction

  task automatic push_pkt(input int ch, input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b = rand_beat(i == len - 1);
      drv_q[ch].push_back(b);
      exp_q[ch].push_back(b);
    end
  endtask

  task automatic drive_heads();
    for (int c = 0; c < N; c++) begin
      if (drv_q[c].size() > 0) begin
        s_data[c*64 +: 64] = drv_q[c][0].data;
        s_user[c*80 +: 80] = drv_q[c][0].user;
        s_keep[c*8 +: 8]   = drv_q[c][0].keep;
        s_last[c]          = drv_q[c][0].last;
      end else begin
        s_data[c*64 +: 64] = '0;
        s_user[c*80 +: 80] = '0;
        s_keep[c*8 +: 8]   = '0;
        s_last[c]          = 1'b0;
      end
    end
  endtask

  // One clock of stimulus: retire handshaken beats, keep un-accepted valids held.
  task automatic step();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (hs[c] === 1'b1 && drv_q[c].size() > 0) begin
        void'(drv_q[c].pop_front());
        hs_cnt[c]++;
        s_valid[c] = 1'b0;
      end
      if (!s_valid[c] && drv_q[c].size() > 0 && $urandom_range(99) >= gap_pct) s_valid[c] = 1'b1;
    end
    drive_heads();
    case (rdy_mode)
      0:       m_rdy = 1'b1;
      1:       m_rdy = ~m_rdy;
      default: m_rdy = ($urandom_range(99) < 70);
    endcase
  endtask

  function automatic int pending();
    int p = 0;
    for (int c = 0; c < N; c++) p += drv_q[c].size();
    return p;
  endfunction

  task automatic drain(input int max_cyc);
    int n = 0;
    while (pending() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", 128'(pending()), 128'(0));
    repeat (3) step();
  endtask

  task automatic reset_pulse();
    @(posedge clk);
    #1;
    i_rst   = 1'b1;
    s_valid = '0;
    for (int c = 0; c < N; c++) begin
      drv_q[c].delete();
      exp_q[c].delete();
    end
    drive_heads();
    @(posedge clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Monitor: compare against model, pop scoreboard on egress handshake, then advance model.
  always @(negedge clk) begin
    beat_t b;
    logic  found;
    if (model_ok) begin
      chk("busy", 128'(busy), 128'(mb_busy));
      chk("grant", 128'(grant), mb_busy ? 128'(4'(1) << mb_g) : 128'(0));
      chk("out_valid", 128'(m_valid), 128'(mb_busy && s_valid[mb_g]));
      chk("s_ready", 128'(s_ready), mb_busy ? 128'(4'(m_rdy) << mb_g) : 128'(0));
      if (mb_busy && s_valid[mb_g] && m_rdy) begin
        if (exp_q[mb_g].size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got beat on ch%0d expected none at %0t", mb_g, $time);
        end else begin
          b = exp_q[mb_g].pop_front();
          chk("data", 128'(m_data), 128'(b.data));
          chk("user", 128'(m_user), 128'(b.user));
          chk("keep", 128'(m_keep), 128'(b.keep));
          chk("last", 128'(m_last), 128'(b.last));
        end
      end
`ifdef ARB_PKT_CNT_EN
      for (int c = 0; c < N; c++) chk("pkt_cnt", 128'(pkt_cnt[c*16 +: 16]), 128'(mb_cnt[c]));
`endif
    end
    hs = s_valid & s_ready;
    if (i_rst === 1'b1) begin
      model_ok = 1'b1;
      mb_busy  = 1'b0;
      mb_g     = 0;
      mb_ptr   = 0;
      for (int c = 0; c < N; c++) mb_cnt[c] = '0;
    end else if (model_ok && !mb_busy) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && s_valid[(mb_ptr + i) % N]) begin
          found = 1'b1;
          mb_g  = (mb_ptr + i) % N;
        end
      end
      mb_busy = found;
    end else if (model_ok && s_valid[mb_g] && m_rdy && s_last[mb_g]) begin
      mb_cnt[mb_g] = mb_cnt[mb_g] + 16'd1;
      mb_ptr       = (mb_g + 1) % N;
      mb_busy      = 1'b0;
    end
  end

  initial begin
    int base;
    int n;
    for (int c = 0; c < N; c++) hs_cnt[c] = 0;
    i_rst   = 1'b1;
    m_rdy   = 1'b1;
    s_valid = '0;
    // Reset held three cycles with every channel requesting; then all four 3-beat packets
    // plus a second ch0 packet must come out in order 0,1,2,3,0.
    for (int c = 0; c < N; c++) push_pkt(c, 3);
    push_pkt(0, 3);
    drive_heads();
    s_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    drain(200);

    // Backpressure on a lone ch2 packet with ready toggling every cycle.
    rdy_mode = 1;
    push_pkt(2, 4);
    drain(100);
    rdy_mode = 0;

    // ch1 locked while ch0 raises valid mid-packet.
    push_pkt(1, 5);
    repeat (3) step();
    push_pkt(0, 2);
    drain(100);

    // Back-to-back single-beat packets on ch3.
    for (int k = 0; k < 4; k++) push_pkt(3, 1);
    drain(100);

    // Reset on beat 3 of a 5-beat ch2 packet; pointer must return to ch0 (ch1 beats ch3).
    push_pkt(2, 5);
    base = hs_cnt[2];
    n    = 0;
    while (hs_cnt[2] - base < 2 && n < 50) begin
      step();
      n++;
    end
    chk("midpkt_progress", 128'(hs_cnt[2] - base), 128'(2));
    reset_pulse();
    push_pkt(3, 2);
    push_pkt(1, 2);
    drain(100);

    // Random traffic with valid gaps and random egress backpressure.
    gap_pct  = 25;
    rdy_mode = 2;
    for (int k = 0; k < 120; k++) begin
      push_pkt(int'($urandom_range(N - 1)), int'($urandom_range(1, 6)));
      repeat ($urandom_range(0, 4)) step();
    end
    drain(4000);

    for (int c = 0; c < N; c++) chk("sb_leftover", 128'(exp_q[c].size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
